// File: rtl/life_board_pkg.sv
// Shared definitions for the Game of Life board.
// Holds the birth and survival neighbour counts, the neighbour count width
// and the generation counter width. The interface, the rule cell and the
// board top all import this package.
package life_board_pkg;

  // Width of the generation counter. The counter wraps at its full range.
  localparam int GEN_W = 16;

  // The neighbour count is 0..8, so it needs 4 bits.
  localparam int NBR_W = 4;

  // A dead cell with exactly LIFE_BIRTH neighbours is born.
  localparam logic [NBR_W-1:0] LIFE_BIRTH   = 4'd3;
  // A live cell with LIFE_SURV_LO..LIFE_SURV_HI neighbours survives.
  localparam logic [NBR_W-1:0] LIFE_SURV_LO = 4'd2;
  localparam logic [NBR_W-1:0] LIFE_SURV_HI = 4'd3;

endpackage

// File: rtl/life_board_if.sv
// Scan/display bundle between the scan counter, the display path and the
// life board.
//   cnt      : scan index, row-major (low LOG2X bits = x, upper bits = y)
//   nxt_bit  : step request for the frame that starts at cnt==0
//   cell_out : registered value of cell cnt (one cycle latency)
//   gen      : generation counter
//   pop      : live cells counted in the last completed frame
// Modports: master = scan counter / display side, slave = life board.
//
// Timing contract: there is no valid/ready handshake. cnt advances by one
// every clock and wraps at N-1. nxt_bit is only sampled on the edge where
// cnt==0, and its value there decides whether the whole frame is stepped.
// cell_out follows cnt by exactly one clock. gen and pop update on the
// edge where cnt==N-1.
interface life_board_if
  import life_board_pkg::*;
#(
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
) ();

  logic [LOG2X+LOG2Y-1:0] cnt;
  logic                   nxt_bit;
  logic                   cell_out;
  logic [GEN_W-1:0]       gen;
  logic [LOG2X+LOG2Y:0]   pop;

  modport master (
    output cnt,
    output nxt_bit,
    input  cell_out,
    input  gen,
    input  pop
  );

  modport slave (
    input  cnt,
    input  nxt_bit,
    output cell_out,
    output gen,
    output pop
  );

endinterface

// File: rtl/life_rule.sv
// Combinational next-state function for one Game of Life cell.
//   self_bit : current state of the cell
//   nbrs     : the 8 neighbour states (the order does not matter)
//   next_bit : state of the cell in the next generation
module life_rule
  import life_board_pkg::*;
(
  input  logic       self_bit,
  input  logic [7:0] nbrs,
  output logic       next_bit
);

  logic [NBR_W-1:0] nbr_cnt;

  always_comb begin
    nbr_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      nbr_cnt = nbr_cnt + {{(NBR_W-1){1'b0}}, nbrs[i]};
    end
  end

  assign next_bit = (nbr_cnt == LIFE_BIRTH) ||
                    (self_bit && (nbr_cnt >= LIFE_SURV_LO) &&
                                 (nbr_cnt <= LIFE_SURV_HI));

endmodule

// File: rtl/life_board.sv
// Cell store and next-generation engine for the Game of Life grid.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : life_board_if.slave (cnt, nxt_bit in; cell_out, gen, pop out)
// The committed grid (cur) is shown one cell per clock as cnt sweeps.
// On a stepped frame, each swept cell's next state goes into shadow.
// At the last cell, shadow is copied into cur in a single edge.
module life_board
  import life_board_pkg::*;
#(
  parameter int             X     = 8,
  parameter int             Y     = 8,
  parameter int             LOG2X = 3,
  parameter int             LOG2Y = 3,
  parameter logic [X*Y-1:0] INIT  = 64'h0000_0000_0007_0402
) (
  input logic         clk,
  input logic         reset,
  life_board_if.slave bus
);

  localparam int N  = X * Y;
  localparam int CW = LOG2X + LOG2Y;

  localparam logic [LOG2X-1:0] ONE_X = LOG2X'(1);
  localparam logic [LOG2Y-1:0] ONE_Y = LOG2Y'(1);
  localparam logic [CW-1:0]    LAST  = CW'(N - 1);

  logic [N-1:0]     cur;
  logic [N-1:0]     shadow;
  logic [N-1:0]     commit_grid;
  logic             step_en;
  logic             frame_seen;
  logic             cell_q;
  logic [GEN_W-1:0] gen_q;
  logic [CW:0]      pop_q;
  logic [CW:0]      pop_acc;

  logic [LOG2X-1:0] x, xl, xr;
  logic [LOG2Y-1:0] y, yu, yd;
  logic [7:0]       nbrs;
  logic             self_bit;
  logic             next_bit;
  logic             first;
  logic             last;
  logic             step_act;

  // The +-1 arithmetic truncates to the index width, so the grid wraps
  // around at its edges (toroidal wrap).
  assign x  = bus.cnt[LOG2X-1:0];
  assign y  = bus.cnt[CW-1:LOG2X];
  assign xl = x - ONE_X;
  assign xr = x + ONE_X;
  assign yu = y - ONE_Y;
  assign yd = y + ONE_Y;

  assign self_bit = cur[bus.cnt];
  assign nbrs = {cur[{yu, xl}], cur[{yu, x}], cur[{yu, xr}],
                 cur[{y,  xl}],               cur[{y,  xr}],
                 cur[{yd, xl}], cur[{yd, x}], cur[{yd, xr}]};

  life_rule u_rule (
    .self_bit (self_bit),
    .nbrs     (nbrs),
    .next_bit (next_bit)
  );

  assign first = (bus.cnt == '0);
  assign last  = (bus.cnt == LAST);

  // step_en is only loaded on the cnt==0 edge. Cell 0 is computed on that
  // same edge, so it has to use nxt_bit directly.
  assign step_act = first ? bus.nxt_bit : step_en;

  // The last cell's next state is only known in the commit cycle itself, so
  // it bypasses shadow.
  always_comb begin
    commit_grid        = shadow;
    commit_grid[N-1]   = next_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= INIT;
      shadow     <= '0;
      step_en    <= 1'b0;
      frame_seen <= 1'b0;
      cell_q     <= 1'b0;
      gen_q      <= '0;
      pop_q      <= '0;
      pop_acc    <= '0;
    end else begin
      cell_q <= self_bit;

      if (first) begin
        step_en    <= bus.nxt_bit;
        frame_seen <= 1'b1;
      end

      if (step_act) begin
        shadow[bus.cnt] <= next_bit;
      end

      if (last) begin
        pop_acc <= '0;
        // If reset was released mid-frame, the first partial frame must not
        // publish a count.
        if (frame_seen) begin
          pop_q <= pop_acc + {{CW{1'b0}}, self_bit};
        end
        if (step_act) begin
          cur   <= commit_grid;
          gen_q <= gen_q + GEN_W'(1);
        end
        step_en <= 1'b0;
      end else begin
        pop_acc <= pop_acc + {{CW{1'b0}}, self_bit};
      end
    end
  end

  assign bus.cell_out = cell_q;
  assign bus.gen      = gen_q;
  assign bus.pop      = pop_q;

endmodule
